// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory controller port between two requesters:
//   port 0 : CPU
//   port 1 : external / debug requester (loader, Arduino bridge)
//
// One request is serviced at a time, chosen round-robin. The granted
// request is driven onto the memory port for exactly one issue cycle. Reads
// then wait MEM_LAT cycles for mem_rdata. Every transaction ends with a
// one-cycle done pulse (plus err and rdata) on the owning port.
//
// Handshake: a requester raises rN_req with its payload and holds both
// until rN_done pulses. The payload is copied at grant, so later changes
// are ignored. The earliest new request is in the cycle after done, and it
// is arbitrated in the following IDLE cycle like any other request.
//
// A vector access whose address is not 16-word aligned is rejected at
// grant. No memory cycle is issued, and the requester gets done with err=1
// one cycle after the request.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rN_req/we/vec/addr/wdata request side of port N (N = 0, 1)
//   rN_done/err/rdata        response side of port N
//   mem_addr/we/vec/wdata    registered drive to the memory controller
//   mem_rdata                read data from the memory controller
//   busy                     FSM is not IDLE
//   gnt_cnt0/1               wrapping grant counters per port
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 13,
  parameter int LANES   = 16,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic                     r0_vec,
  input  logic [ADDR_W-1:0]        r0_addr,
  input  logic [LANES*DATA_W-1:0]  r0_wdata,
  output logic                     r0_done,
  output logic                     r0_err,
  output logic [LANES*DATA_W-1:0]  r0_rdata,

  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic                     r1_vec,
  input  logic [ADDR_W-1:0]        r1_addr,
  input  logic [LANES*DATA_W-1:0]  r1_wdata,
  output logic                     r1_done,
  output logic                     r1_err,
  output logic [LANES*DATA_W-1:0]  r1_rdata,

  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic                     mem_vec,
  output logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic [LANES*DATA_W-1:0]  mem_rdata,

  output logic                     busy,
  output logic [31:0]              gnt_cnt0,
  output logic [31:0]              gnt_cnt1
);

  localparam int BUS_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic               own;         // port that owns the current transaction
  logic               last_grant;  // port granted most recently
  logic [3:0]         wait_cnt;
  logic [BUS_W-1:0]   rdata_q;     // last data read from memory

  // -------------------------------------------------------------------------
  // Arbitration: a lone request wins outright. On a tie, the port that was
  // not granted last wins. last_grant resets to 1, so port 0 wins the first
  // tie.
  // -------------------------------------------------------------------------
  logic               pick_valid;
  logic               pick;
  logic               pick_we;
  logic               pick_vec;
  logic [ADDR_W-1:0]  pick_addr;
  logic [BUS_W-1:0]   pick_wdata;
  logic               pick_misalign;

  always_comb begin
    pick_valid = r0_req | r1_req;
    if (r0_req && r1_req) begin
      pick = ~last_grant;
    end else begin
      pick = r1_req;
    end
    pick_we       = pick ? r1_we    : r0_we;
    pick_vec      = pick ? r1_vec   : r0_vec;
    pick_addr     = pick ? r1_addr  : r0_addr;
    pick_wdata    = pick ? r1_wdata : r0_wdata;
    pick_misalign = pick_vec && (pick_addr[3:0] != 4'd0);
  end

  // -------------------------------------------------------------------------
  // Response selection. A response is launched on the edge that enters RESP,
  // so done/err/rdata are registered and visible throughout the RESP cycle.
  // Sources:
  //   IDLE  misaligned vector grant -> err, rdata register unchanged
  //   ISSUE write                   -> rdata register unchanged
  //   WAIT  last wait cycle         -> live mem_rdata (also captured)
  // -------------------------------------------------------------------------
  logic               resp_fire;
  logic               resp_port;
  logic               resp_err;
  logic [BUS_W-1:0]   resp_rdata;

  always_comb begin
    resp_fire  = 1'b0;
    resp_port  = own;
    resp_err   = 1'b0;
    resp_rdata = rdata_q;
    case (state)
      IDLE: begin
        if (pick_valid && pick_misalign) begin
          resp_fire = 1'b1;
          resp_port = pick;
          resp_err  = 1'b1;
        end
      end
      ISSUE: begin
        // mem_we is the latched write flag during ISSUE.
        if (mem_we) begin
          resp_fire = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd1) begin
          resp_fire  = 1'b1;
          resp_rdata = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own        <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= 4'd0;
      rdata_q    <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_vec    <= 1'b0;
      mem_wdata  <= '0;
      gnt_cnt0   <= 32'd0;
      gnt_cnt1   <= 32'd0;
      r0_done    <= 1'b0;
      r0_err     <= 1'b0;
      r0_rdata   <= '0;
      r1_done    <= 1'b0;
      r1_err     <= 1'b0;
      r1_rdata   <= '0;
    end else begin
      // Done pulses and the write strobe last for exactly one cycle.
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      mem_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            own        <= pick;
            last_grant <= pick;
            if (pick) begin
              gnt_cnt1 <= gnt_cnt1 + 32'd1;
            end else begin
              gnt_cnt0 <= gnt_cnt0 + 32'd1;
            end
            if (pick_misalign) begin
              // The memory port is left untouched and no access happens.
              state <= RESP;
            end else begin
              mem_addr  <= pick_addr;
              mem_we    <= pick_we;
              mem_vec   <= pick_vec;
              mem_wdata <= pick_wdata;
              state     <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (mem_we) begin
            state <= RESP;
          end else begin
            wait_cnt <= 4'(MEM_LAT);
            state    <= WAIT;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            rdata_q <= mem_rdata;
            state   <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // The non-owner's err and rdata keep their previous values.
      if (resp_fire) begin
        if (resp_port) begin
          r1_done  <= 1'b1;
          r1_err   <= resp_err;
          r1_rdata <= resp_rdata;
        end else begin
          r0_done  <= 1'b1;
          r0_err   <= resp_err;
          r0_rdata <= resp_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. The main instance uses MEM_LAT=1 and a
// second instance uses MEM_LAT=4. Both share all inputs; the second
// instance is only examined in the latency step, right after a reset.
// Each expected completion is queued when its request is driven, then
// popped and compared when a done pulse appears on the main instance.
// Cycle numbering: inputs change on the falling edge of "cycle 0", and
// outputs are sampled on later falling edges.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W = 13;
  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int BUS_W  = LANES * DATA_W;

  // ---- clock / reset -------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- shared stimulus -----------------------------------------------------
  logic              r0_req = 0, r0_we = 0, r0_vec = 0;
  logic [ADDR_W-1:0] r0_addr = '0;
  logic [BUS_W-1:0]  r0_wdata = '0;
  logic              r1_req = 0, r1_we = 0, r1_vec = 0;
  logic [ADDR_W-1:0] r1_addr = '0;
  logic [BUS_W-1:0]  r1_wdata = '0;
  logic [BUS_W-1:0]  mem_rdata = '0;

  // ---- main instance (MEM_LAT=1) outputs ----------------------------------
  logic              r0_done, r0_err, r1_done, r1_err;
  logic [BUS_W-1:0]  r0_rdata, r1_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_vec, busy;
  logic [31:0]       gnt_cnt0, gnt_cnt1;

  // ---- second instance (MEM_LAT=4) outputs --------------------------------
  logic              r0_done4, r0_err4, r1_done4, r1_err4;
  logic [BUS_W-1:0]  r0_rdata4, r1_rdata4, mem_wdata4;
  logic [ADDR_W-1:0] mem_addr4;
  logic              mem_we4, mem_vec4, busy4;
  logic [31:0]       gnt_cnt0_4, gnt_cnt1_4;

  dmem_arbiter #(.MEM_LAT(1), .ADDR_W(ADDR_W), .LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_vec(r0_vec), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_vec(r1_vec), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_vec(mem_vec), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  dmem_arbiter #(.MEM_LAT(4), .ADDR_W(ADDR_W), .LANES(LANES), .DATA_W(DATA_W)) dut4 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_vec(r0_vec), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done4), .r0_err(r0_err4), .r0_rdata(r0_rdata4),
    .r1_req(r1_req), .r1_we(r1_we), .r1_vec(r1_vec), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done4), .r1_err(r1_err4), .r1_rdata(r1_rdata4),
    .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_vec(mem_vec4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata), .busy(busy4), .gnt_cnt0(gnt_cnt0_4), .gnt_cnt1(gnt_cnt1_4)
  );

  // ---- scoreboard ----------------------------------------------------------
  typedef struct {
    int               port;
    logic             err;
    logic [BUS_W-1:0] rdata;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b1;
  logic [BUS_W-1:0] last_rd = '0;  // model of the arbiter's rdata register

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_done(input int port, input logic err, input logic [BUS_W-1:0] rd, input int lat);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (r0_done && r1_done) chk("done_overlap", 1, 0);
      if (r0_done || r1_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_port", BUS_W'(r1_done ? 1 : 0), BUS_W'(e.port));
          chk("done_cycle", BUS_W'(cyc), BUS_W'(e.cyc));
          chk("done_err", BUS_W'(r1_done ? r1_err : r0_err), BUS_W'(e.err));
          chk("done_rdata", r1_done ? r1_rdata : r0_rdata, e.rdata);
        end
      end
    end
  end

  // ---- driver helpers ------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [BUS_W-1:0] garbage();
    logic [BUS_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom();
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    r0_req = 0;
    r1_req = 0;
    tick();
    rst = 1'b0;
    last_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---- directed sequence ---------------------------------------------------
  initial begin
    logic [BUS_W-1:0] d;
    logic [BUS_W-1:0] lanes;
    mem_rdata = garbage();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", BUS_W'(busy), 0);
    chk("rst_mem_we", BUS_W'(mem_we), 0);
    chk("rst_mem_addr", BUS_W'(mem_addr), 0);
    chk("rst_gnt0", BUS_W'(gnt_cnt0), 0);
    chk("rst_gnt1", BUS_W'(gnt_cnt1), 0);
    chk("rst_r0_rdata", r0_rdata, 0);

    // 1. single scalar read on port 0
    d = '0;
    d[31:0] = 32'hDEADBEEF;
    r0_req = 1; r0_we = 0; r0_vec = 0; r0_addr = 13'h010;
    expect_done(0, 1'b0, d, 3);
    last_rd = d;
    tick();                                     // cycle 1
    chk("t1_mem_we", BUS_W'(mem_we), 0);
    chk("t1_mem_addr", BUS_W'(mem_addr), BUS_W'(13'h010));
    chk("t1_busy", BUS_W'(busy), 1);
    tick();                                     // cycle 2: data valid
    mem_rdata = d;
    tick();                                     // cycle 3: done
    mem_rdata = garbage();
    r0_req = 0;
    chk("t1_gnt0", BUS_W'(gnt_cnt0), 1);
    tick();

    // 2. vector write on port 1
    for (int i = 0; i < LANES; i++) lanes[i*DATA_W +: DATA_W] = DATA_W'(i);
    r1_req = 1; r1_we = 1; r1_vec = 1; r1_addr = 13'h020; r1_wdata = lanes;
    expect_done(1, 1'b0, last_rd, 2);
    tick();                                     // cycle 1: issue
    chk("t2_mem_we", BUS_W'(mem_we), 1);
    chk("t2_mem_vec", BUS_W'(mem_vec), 1);
    chk("t2_mem_addr", BUS_W'(mem_addr), BUS_W'(13'h020));
    chk("t2_mem_wdata", mem_wdata, lanes);
    r1_wdata = garbage();                       // ignored while granted
    tick();                                     // cycle 2: done
    chk("t2_mem_we_off", BUS_W'(mem_we), 0);
    chk("t2_wdata_hold", mem_wdata, lanes);
    r1_req = 0;
    tick();                                     // cycle 3
    chk("t2_busy", BUS_W'(busy), 0);
    chk("t2_gnt1", BUS_W'(gnt_cnt1), 1);

    // 3. contention: both ports hold scalar write requests
    do_reset();
    r0_req = 1; r0_we = 1; r0_vec = 0; r0_addr = 13'h100; r0_wdata = garbage();
    r1_req = 1; r1_we = 1; r1_vec = 0; r1_addr = 13'h200; r1_wdata = garbage();
    expect_done(0, 1'b0, '0, 2);
    expect_done(1, 1'b0, '0, 5);
    expect_done(0, 1'b0, '0, 8);
    expect_done(1, 1'b0, '0, 11);
    for (int k = 1; k <= 11; k++) begin
      tick();
      case (k)
        1:  chk("t3_addr_g1", BUS_W'(mem_addr), BUS_W'(13'h100));
        2:  r0_addr = 13'h101;
        4:  chk("t3_addr_g2", BUS_W'(mem_addr), BUS_W'(13'h200));
        5:  r1_addr = 13'h201;
        7:  chk("t3_addr_g3", BUS_W'(mem_addr), BUS_W'(13'h101));
        8:  r0_req = 0;
        10: chk("t3_addr_g4", BUS_W'(mem_addr), BUS_W'(13'h201));
        11: r1_req = 0;
        default: ;
      endcase
    end
    chk("t3_gnt0", BUS_W'(gnt_cnt0), 2);
    chk("t3_gnt1", BUS_W'(gnt_cnt1), 2);

    // 4. misaligned vector on port 0
    tick();
    r0_req = 1; r0_we = 0; r0_vec = 1; r0_addr = 13'h013;
    expect_done(0, 1'b1, last_rd, 1);
    tick();                                     // cycle 1: done + err
    chk("t4_mem_we_c1", BUS_W'(mem_we), 0);
    chk("t4_mem_addr_hold", BUS_W'(mem_addr), BUS_W'(13'h201));
    r0_req = 0;
    tick();                                     // cycle 2
    chk("t4_mem_we_c2", BUS_W'(mem_we), 0);
    chk("t4_busy", BUS_W'(busy), 0);
    chk("t4_gnt0", BUS_W'(gnt_cnt0), 3);

    // 6. reset during WAIT
    r0_req = 1; r0_we = 0; r0_vec = 0; r0_addr = 13'h040;
    tick();                                     // cycle 1: issue
    tick();                                     // cycle 2: wait
    rst = 1'b1;
    tick();                                     // cycle 3: reset state
    rst = 1'b0;
    last_rd = '0;
    chk("t6_busy", BUS_W'(busy), 0);
    chk("t6_done", BUS_W'({r0_done, r1_done}), 0);
    chk("t6_gnt0", BUS_W'(gnt_cnt0), 0);
    chk("t6_mem_addr", BUS_W'(mem_addr), 0);
    chk("t6_r0_rdata", r0_rdata, 0);
    chk("t6_r0_err", BUS_W'(r0_err), 0);
    r0_req = 1; r0_we = 1; r0_vec = 0; r0_addr = 13'h050;
    r1_req = 1; r1_we = 1; r1_vec = 0; r1_addr = 13'h060;
    expect_done(0, 1'b0, '0, 2);
    expect_done(1, 1'b0, '0, 5);
    tick();
    chk("t6_tie_addr", BUS_W'(mem_addr), BUS_W'(13'h050));
    tick();
    r0_req = 0;
    tick();
    tick();
    tick();
    r1_req = 0;
    tick();
    chk("t6_gnt1", BUS_W'(gnt_cnt1), 1);

    // 5. MEM_LAT=4 read on port 1 (second instance)
    mon_en = 1'b0;
    do_reset();
    d = garbage();
    r1_req = 1; r1_we = 0; r1_vec = 0; r1_addr = 13'h030;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("t5_r1_done_c%0d", k), BUS_W'(r1_done4), BUS_W'(k == 6));
      chk($sformatf("t5_r0_done_c%0d", k), BUS_W'(r0_done4), 0);
      if (k == 6) begin
        chk("t5_rdata", r1_rdata4, d);
        chk("t5_err", BUS_W'(r1_err4), 0);
        chk("t5_gnt1", BUS_W'(gnt_cnt1_4), 1);
        r1_req = 0;
      end
      mem_rdata = (k == 5) ? d : garbage();
    end

    chk("queue_empty", BUS_W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
